sys_throttle_ctrl: RTL and testbench

- Sequences FM_SYS_THROTTLE_N for the PCIe slots, the risers and the internal MEMHOT/PROCHOT fan-out.
- Two requesters share the single throttle output: the PCH throttle request and the PDB PMBus alert. The PMBus alert is gated by the PCH alert-enable.
- The block synchronises and glitch-filters the requests, enforces a minimum assertion width, and reports the active and first sources plus a saturating event count for BMC/debug readout.

---
 rtl/sys_throttle_pkg.sv | 24 ++
 rtl/throttle_glitch_filter.sv | 37 +++
 rtl/sys_throttle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sys_throttle_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_throttle_pkg.sv
// Shared definitions for the system throttle controller: FSM encodings,
// source bit positions, default parameter values and a counter-width helper.
package sys_throttle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_STRETCH = 2'd2
  } throttleStateE;

  localparam int SRC_PCH = 0;
  localparam int SRC_PMB = 1;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_FILT_CYC       = 4;
  localparam int DEF_MIN_ASSERT_CYC = 1000;
  localparam int DEF_CNT_W          = 8;

  // Bits needed to hold values 0..maxVal, never less than one bit.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/throttle_glitch_filter.sv
// Level filter: the output follows the raw input only after the input has
// held the opposite value for FILT_CYC consecutive cycles.
module throttle_glitch_filter
  import sys_throttle_pkg::*;
#(
  parameter int FILT_CYC = DEF_FILT_CYC
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iRaw,
  output logic oLevel
);

  localparam int CW = cntWidth(FILT_CYC);
  localparam logic [CW-1:0] LAST_CNT = CW'(FILT_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Any cycle where the raw level agrees with the output restarts the count.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (iRaw == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_level <= iRaw;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign oLevel = r_level;

endmodule

// File: rtl/sys_throttle_ctrl.sv
// Drives FM_SYS_THROTTLE_N from the PCH throttle request and the enabled PDB
// PMBus alert, with a minimum low width and source/event readout.
module sys_throttle_ctrl
  import sys_throttle_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int FILT_CYC       = DEF_FILT_CYC,
  parameter int MIN_ASSERT_CYC = DEF_MIN_ASSERT_CYC,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iFmThrottle_n,
  input  logic             iIrqSml1PmbusAlert_n,
  input  logic             iFmPmbusAlertBEna,
  input  logic             iEventClr,
  output logic             oFmSysThrottle_n,
  output logic [1:0]       oThrottleSrc,
  output logic [1:0]       oFirstSrc,
  output logic [CNT_W-1:0] oEventCnt
);

  localparam int HOLD_W = cntWidth(MIN_ASSERT_CYC);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_ASSERT_CYC);

  logic [SYNC_STAGES-1:0] r_thrSync;
  logic [SYNC_STAGES-1:0] r_alertSync;
  logic [SYNC_STAGES-1:0] r_enaSync;

  logic        w_srcPch;
  logic        w_pmbRaw;
  logic        w_srcPmb;
  logic        w_anySrc;
  logic [1:0]  w_srcNow;
  logic        w_holdMet;
  logic        w_entry;
  logic        w_evtSat;

  throttleStateE     r_state;
  throttleStateE     w_nextState;
  logic [HOLD_W-1:0] r_holdCnt;
  logic              r_throttle_n;
  logic [1:0]        r_throttleSrc;
  logic [1:0]        r_firstSrc;
  logic [CNT_W-1:0]  r_eventCnt;

  // Active-low inputs reset to their idle level of 1 so reset never looks like a request.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_thrSync   <= '1;
      r_alertSync <= '1;
      r_enaSync   <= '0;
    end else begin
      r_thrSync[0]   <= iFmThrottle_n;
      r_alertSync[0] <= iIrqSml1PmbusAlert_n;
      r_enaSync[0]   <= iFmPmbusAlertBEna;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_thrSync[i]   <= r_thrSync[i-1];
        r_alertSync[i] <= r_alertSync[i-1];
        r_enaSync[i]   <= r_enaSync[i-1];
      end
    end
  end

  assign w_srcPch = ~r_thrSync[SYNC_STAGES-1];
  assign w_pmbRaw = ~r_alertSync[SYNC_STAGES-1] & r_enaSync[SYNC_STAGES-1];

  throttle_glitch_filter #(
    .FILT_CYC (FILT_CYC)
  ) u_pmbFilter (
    .iClk   (iClk),
    .iRst   (iRst),
    .iRaw   (w_pmbRaw),
    .oLevel (w_srcPmb)
  );

  always_comb begin
    w_srcNow          = 2'b00;
    w_srcNow[SRC_PCH] = w_srcPch;
    w_srcNow[SRC_PMB] = w_srcPmb;
  end

  assign w_anySrc  = w_srcPch | w_srcPmb;
  assign w_holdMet = (r_holdCnt >= HOLD_MAX);
  assign w_evtSat  = &r_eventCnt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // STRETCH keeps the output low after the sources vanish until the hold count is met.
  always_comb begin
    w_nextState = r_state;
    w_entry     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_anySrc) begin
          w_nextState = ST_ASSERT;
          w_entry     = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (!w_anySrc) begin
          w_nextState = w_holdMet ? ST_IDLE : ST_STRETCH;
        end
      end
      ST_STRETCH: begin
        if (w_anySrc) begin
          w_nextState = ST_ASSERT;
        end else if (w_holdMet) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_holdCnt <= '0;
    end else if (w_entry) begin
      r_holdCnt <= HOLD_W'(1);
    end else if (w_nextState == ST_IDLE) begin
      r_holdCnt <= '0;
    end else if (!w_holdMet) begin
      r_holdCnt <= r_holdCnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_throttle_n  <= 1'b1;
      r_throttleSrc <= 2'b00;
      r_firstSrc    <= 2'b00;
    end else begin
      r_throttle_n  <= (w_nextState == ST_IDLE);
      r_throttleSrc <= w_srcNow;
      if (w_entry) begin
        r_firstSrc <= w_srcNow;
      end
    end
  end

  // A clear that coincides with a new episode still counts that episode.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_eventCnt <= '0;
    end else if (iEventClr) begin
      r_eventCnt <= w_entry ? CNT_W'(1) : '0;
    end else if (w_entry && !w_evtSat) begin
      r_eventCnt <= r_eventCnt + CNT_W'(1);
    end
  end

  assign oFmSysThrottle_n = r_throttle_n;
  assign oThrottleSrc     = r_throttleSrc;
  assign oFirstSrc        = r_firstSrc;
  assign oEventCnt        = r_eventCnt;

endmodule

// File: tb/tb_sys_throttle_ctrl.sv
// Directed bench for sys_throttle_ctrl: a vector table of single episodes plus
// hand sequences for stretch, enable gating, saturation and reset.
module tb_sys_throttle_ctrl;
  import sys_throttle_pkg::*;

  logic       clk;
  logic       rst;
  logic       thrN, alertN, alertEna, eventClr;
  logic       throttleN;
  logic [1:0] throttleSrc, firstSrc;
  logic [7:0] eventCnt;

  logic       fThrN, fAlertN, fAlertEna, fEventClr;
  logic       fThrottleN;
  logic [1:0] fThrottleSrc, fFirstSrc;
  logic [7:0] fEventCnt;

  int checks = 0;
  int errors = 0;
  int expCnt = 0;

  typedef struct {
    int         pchLen;
    int         pmbLen;
    logic       ena;
    int         expLat;
    logic [1:0] expFirst;
    int         expDelta;
  } vecT;

  vecT vecs[7];

  sys_throttle_ctrl #(
    .SYNC_STAGES(2), .FILT_CYC(4), .MIN_ASSERT_CYC(1000), .CNT_W(8)
  ) u_dut (
    .iClk                 (clk),
    .iRst                 (rst),
    .iFmThrottle_n        (thrN),
    .iIrqSml1PmbusAlert_n (alertN),
    .iFmPmbusAlertBEna    (alertEna),
    .iEventClr            (eventClr),
    .oFmSysThrottle_n     (throttleN),
    .oThrottleSrc         (throttleSrc),
    .oFirstSrc            (firstSrc),
    .oEventCnt            (eventCnt)
  );

  sys_throttle_ctrl #(
    .SYNC_STAGES(2), .FILT_CYC(1), .MIN_ASSERT_CYC(2), .CNT_W(8)
  ) u_dutFast (
    .iClk                 (clk),
    .iRst                 (rst),
    .iFmThrottle_n        (fThrN),
    .iIrqSml1PmbusAlert_n (fAlertN),
    .iFmPmbusAlertBEna    (fAlertEna),
    .iEventClr            (fEventClr),
    .oFmSysThrottle_n     (fThrottleN),
    .oThrottleSrc         (fThrottleSrc),
    .oFirstSrc            (fFirstSrc),
    .oEventCnt            (fEventCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic thr, input logic alert, input logic ena);
    thrN     = thr;
    alertN   = alert;
    alertEna = ena;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic runVector(input vecT v, input int idx);
    int lowStart;
    int lowEnd;
    lowStart = 0;
    lowEnd   = 0;
    @(posedge clk); #1;
    applyStimulus((v.pchLen > 0) ? 1'b0 : 1'b1, (v.pmbLen > 0) ? 1'b0 : 1'b1, v.ena);
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (k == v.pchLen) thrN = 1'b1;
      if (k == v.pmbLen) alertN = 1'b1;
      if (throttleN == 1'b0 && lowStart == 0) lowStart = k;
      if (lowStart != 0 && throttleN == 1'b1 && lowEnd == 0) lowEnd = k;
    end
    alertEna = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    expCnt += v.expDelta;
    checkOutput($sformatf("vec%0d latency", idx), lowStart, v.expLat);
    if (v.expLat != 0) begin
      checkOutput($sformatf("vec%0d lowWidth", idx), lowEnd - lowStart, 1000);
      checkOutput($sformatf("vec%0d firstSrc", idx), firstSrc, v.expFirst);
    end
    checkOutput($sformatf("vec%0d eventCnt", idx), eventCnt, expCnt);
  endtask

  initial begin
    int lowStart;
    int lowEnd;
    int lowSeen;

    vecs[0] = '{pchLen: 10, pmbLen: 0,  ena: 1'b0, expLat: 3, expFirst: 2'b01, expDelta: 1};
    vecs[1] = '{pchLen: 0,  pmbLen: 3,  ena: 1'b1, expLat: 0, expFirst: 2'b00, expDelta: 0};
    vecs[2] = '{pchLen: 0,  pmbLen: 20, ena: 1'b1, expLat: 7, expFirst: 2'b10, expDelta: 1};
    vecs[3] = '{pchLen: 0,  pmbLen: 20, ena: 1'b0, expLat: 0, expFirst: 2'b00, expDelta: 0};
    vecs[4] = '{pchLen: 20, pmbLen: 20, ena: 1'b1, expLat: 3, expFirst: 2'b01, expDelta: 1};
    vecs[5] = '{pchLen: 1,  pmbLen: 0,  ena: 1'b0, expLat: 3, expFirst: 2'b01, expDelta: 1};
    vecs[6] = '{pchLen: 0,  pmbLen: 4,  ena: 1'b1, expLat: 7, expFirst: 2'b10, expDelta: 1};

    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    eventClr  = 1'b0;
    fThrN     = 1'b1;
    fAlertN   = 1'b1;
    fAlertEna = 1'b0;
    fEventClr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset throttleN", throttleN, 1);
    checkOutput("reset throttleSrc", throttleSrc, 0);
    checkOutput("reset firstSrc", firstSrc, 0);
    checkOutput("reset eventCnt", eventCnt, 0);
    checkOutput("reset fast throttleN", fThrottleN, 1);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      runVector(vecs[i], i);
    end

    // Enable gating: alert held low while disabled, then enabled, then disabled.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    lowSeen = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (throttleN == 1'b0) lowSeen++;
    end
    checkOutput("gated alert low cycles", lowSeen, 0);
    alertEna = 1'b1;
    lowStart = 0;
    lowEnd   = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (k == 50) alertEna = 1'b0;
      if (k == 27) checkOutput("enabled throttleSrc", throttleSrc, 2);
      if (k == 70) checkOutput("disabled throttleSrc", throttleSrc, 0);
      if (throttleN == 1'b0 && lowStart == 0) lowStart = k;
      if (lowStart != 0 && throttleN == 1'b1 && lowEnd == 0) lowEnd = k;
    end
    alertN = 1'b1;
    expCnt++;
    checkOutput("enable latency", lowStart, 7);
    checkOutput("enable lowWidth", lowEnd - lowStart, 1000);
    checkOutput("enable firstSrc", firstSrc, 2);
    checkOutput("enable eventCnt", eventCnt, expCnt);
    repeat (10) @(posedge clk);

    // Re-assert during STRETCH: one continuous episode from the original entry.
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    lowStart = 0;
    lowEnd   = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (k == 100) thrN = 1'b1;
      if (k == 500) thrN = 1'b0;
      if (k == 600) thrN = 1'b1;
      if (k == 300) checkOutput("stretch state", int'(u_dut.r_state), int'(ST_STRETCH));
      if (k == 550) checkOutput("reassert state", int'(u_dut.r_state), int'(ST_ASSERT));
      if (throttleN == 1'b0 && lowStart == 0) lowStart = k;
      if (lowStart != 0 && throttleN == 1'b1 && lowEnd == 0) lowEnd = k;
    end
    expCnt++;
    checkOutput("stretch latency", lowStart, 3);
    checkOutput("stretch release", lowEnd, 1003);
    checkOutput("stretch firstSrc", firstSrc, 1);
    checkOutput("stretch eventCnt", eventCnt, expCnt);
    repeat (10) @(posedge clk);

    // Both sources qualify on the same cycle.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    lowStart = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (k == 4) thrN = 1'b0;
      if (k == 20) begin
        thrN   = 1'b1;
        alertN = 1'b1;
      end
      if (throttleN == 1'b0 && lowStart == 0) lowStart = k;
    end
    alertEna = 1'b0;
    expCnt++;
    checkOutput("simultaneous latency", lowStart, 7);
    checkOutput("simultaneous firstSrc", firstSrc, 3);
    checkOutput("simultaneous eventCnt", eventCnt, expCnt);
    repeat (10) @(posedge clk);

    // Saturation and clear on the short-hold instance.
    for (int e = 0; e < 300; e++) begin
      @(posedge clk); #1;
      fThrN = 1'b0;
      @(posedge clk); #1;
      fThrN = 1'b1;
      repeat (8) @(posedge clk);
    end
    #1;
    checkOutput("fast saturated eventCnt", fEventCnt, 255);
    @(posedge clk); #1;
    fThrN = 1'b0;
    @(posedge clk); #1;
    fThrN = 1'b1;
    @(posedge clk); #1;
    fEventClr = 1'b1;
    @(posedge clk); #1;
    fEventClr = 1'b0;
    checkOutput("fast clr on entry eventCnt", fEventCnt, 1);
    checkOutput("fast clr on entry throttleN", fThrottleN, 0);
    checkOutput("fast clr on entry firstSrc", fFirstSrc, 1);
    repeat (8) @(posedge clk);
    #1;
    fEventClr = 1'b1;
    @(posedge clk); #1;
    fEventClr = 1'b0;
    checkOutput("fast clr alone eventCnt", fEventCnt, 0);

    // Asynchronous reset in the middle of an episode.
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset throttleN", throttleN, 1);
    checkOutput("midreset throttleSrc", throttleSrc, 0);
    checkOutput("midreset firstSrc", firstSrc, 0);
    checkOutput("midreset eventCnt", eventCnt, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    lowStart = 0;
    lowEnd   = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (k == 10) thrN = 1'b1;
      if (throttleN == 1'b0 && lowStart == 0) lowStart = k;
      if (lowStart != 0 && throttleN == 1'b1 && lowEnd == 0) lowEnd = k;
    end
    checkOutput("postreset latency", lowStart, 3);
    checkOutput("postreset lowWidth", lowEnd - lowStart, 1000);
    checkOutput("postreset eventCnt", eventCnt, 1);
    checkOutput("postreset firstSrc", firstSrc, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
